// File: rtl/pwm_dt_pkg.sv
// Shared types and constants for the PWM dead-time stage.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package pwm_dt_pkg;

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    LO_ON   = 3'd1,
    DT_RISE = 3'd2,
    HI_ON   = 3'd3,
    DT_FALL = 3'd4
  } dt_state_e;

  // Byte addresses of the register map
  localparam int unsigned ADR_CTRL    = 32'h00;
  localparam int unsigned ADR_DT_RISE = 32'h04;
  localparam int unsigned ADR_DT_FALL = 32'h08;
  localparam int unsigned ADR_STATUS  = 32'h0C;

  // CTRL bit positions
  localparam int unsigned CTRL_W          = 4;
  localparam int unsigned CTRL_EN         = 0;
  localparam int unsigned CTRL_POL_HI     = 1;
  localparam int unsigned CTRL_POL_LO     = 2;
  localparam int unsigned CTRL_FORCE_SAFE = 3;

endpackage

// File: rtl/pwm_dt_sync.sv
// Two-flop synchronizer bringing the raw PWM into the clk_i domain.
// Latency: 2 clk_i cycles.
// Backpressure: none; free-running sampler.
module pwm_dt_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Shift the input through the two synchronizer stages
  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  // Synchronizer flops, cleared by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary high/low PWM driver with programmable rising/falling dead time.
// Latency: pwm_i edge to outputs 1 cycle, or 3 cycles with PWMDT_SYNC_EN (input synchronizer).
// Backpressure: none; register reads are combinational, writes take effect next cycle.
module pwm_deadtime
  import pwm_dt_pkg::*;
#(
  parameter int DT_W   = 16,
  parameter int STAT_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              re_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  input  logic              pwm_i,
  output logic              pwm_hi_o,
  output logic              pwm_lo_o,
  output logic              oe_hi_o,
  output logic              oe_lo_o
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DT_W-1:0]   dt_rise_q, dt_rise_d;
  logic [DT_W-1:0]   dt_fall_q, dt_fall_d;
  logic [STAT_W-1:0] status_q, status_d;
  dt_state_e         state_q, state_d;
  logic [DT_W-1:0]   cnt_q, cnt_d;
  logic              pwm_hi_q, pwm_hi_d;
  logic              pwm_lo_q, pwm_lo_d;
  logic              oe_q, oe_d;

  logic pwm_s;
  logic swallow;
  logic wr_en;
  logic sel_ctrl, sel_dt_rise, sel_dt_fall, sel_status;
  logic en, pol_hi, pol_lo, force_safe;
  logic unused_wdata;

  // Raw PWM either comes from another clock domain or is already local
`ifdef PWMDT_SYNC_EN
  pwm_dt_sync u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (pwm_i),
    .q_o    (pwm_s)
  );
`else
  assign pwm_s = pwm_i;
`endif

  assign wr_en        = we_i & ~re_i;
  assign sel_ctrl     = (addr_i == ADDR_W'(ADR_CTRL));
  assign sel_dt_rise  = (addr_i == ADDR_W'(ADR_DT_RISE));
  assign sel_dt_fall  = (addr_i == ADDR_W'(ADR_DT_FALL));
  assign sel_status   = (addr_i == ADDR_W'(ADR_STATUS));
  assign unused_wdata = ^wdata_i[31:DT_W];

  assign en         = ctrl_q[CTRL_EN];
  assign pol_hi     = ctrl_q[CTRL_POL_HI];
  assign pol_lo     = ctrl_q[CTRL_POL_LO];
  assign force_safe = ctrl_q[CTRL_FORCE_SAFE];

  // Register write decode; a STATUS write clears even if a swallow lands the same cycle
  always_comb begin
    ctrl_d    = ctrl_q;
    dt_rise_d = dt_rise_q;
    dt_fall_d = dt_fall_q;
    status_d  = status_q;
    if (swallow && (status_q != '1)) begin
      status_d = status_q + STAT_W'(1);
    end
    if (wr_en) begin
      if (sel_ctrl)    ctrl_d    = wdata_i[CTRL_W-1:0];
      if (sel_dt_rise) dt_rise_d = wdata_i[DT_W-1:0];
      if (sel_dt_fall) dt_fall_d = wdata_i[DT_W-1:0];
      if (sel_status)  status_d  = '0;
    end
  end

  // Configuration and status registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q    <= '0;
      dt_rise_q <= '0;
      dt_fall_q <= '0;
      status_q  <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      dt_rise_q <= dt_rise_d;
      dt_fall_q <= dt_fall_d;
      status_q  <= status_d;
    end
  end

  // Combinational read mux, zero-extended; unmapped addresses read 0
  always_comb begin
    rdata_o = '0;
    if (sel_ctrl)    rdata_o = 32'(ctrl_q);
    if (sel_dt_rise) rdata_o = 32'(dt_rise_q);
    if (sel_dt_fall) rdata_o = 32'(dt_fall_q);
    if (sel_status)  rdata_o = 32'(status_q);
  end

  // FSM state and dead-time counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: disable/force_safe override everything; a DT state counts down the loaded gap
  // and a pwm_s reversal inside the gap swallows the pulse. cnt of 0 (DT=0 entered from OFF)
  // exits like cnt of 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    swallow = 1'b0;
    if (!en || force_safe) begin
      state_d = OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        OFF: begin
          if (pwm_s) begin
            state_d = DT_RISE;
            cnt_d   = dt_rise_q;
          end else begin
            state_d = LO_ON;
          end
        end
        LO_ON: begin
          if (pwm_s) begin
            if (dt_rise_q == '0) begin
              state_d = HI_ON;
            end else begin
              state_d = DT_RISE;
              cnt_d   = dt_rise_q;
            end
          end
        end
        DT_RISE: begin
          if (!pwm_s) begin
            state_d = LO_ON;
            cnt_d   = '0;
            swallow = 1'b1;
          end else if (cnt_q <= DT_W'(1)) begin
            state_d = HI_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end
        HI_ON: begin
          if (!pwm_s) begin
            if (dt_fall_q == '0) begin
              state_d = LO_ON;
            end else begin
              state_d = DT_FALL;
              cnt_d   = dt_fall_q;
            end
          end
        end
        DT_FALL: begin
          if (pwm_s) begin
            state_d = HI_ON;
            cnt_d   = '0;
            swallow = 1'b1;
          end else if (cnt_q <= DT_W'(1)) begin
            state_d = LO_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end
        default: begin
          state_d = OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output levels follow the next state so pads switch together with the state register
  always_comb begin
    pwm_hi_d = (state_d == HI_ON) ^ pol_hi;
    pwm_lo_d = (state_d == LO_ON) ^ pol_lo;
    oe_d     = en;
  end

  // Registered pad drives and enables
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pwm_hi_q <= 1'b0;
      pwm_lo_q <= 1'b0;
      oe_q     <= 1'b0;
    end else begin
      pwm_hi_q <= pwm_hi_d;
      pwm_lo_q <= pwm_lo_d;
      oe_q     <= oe_d;
    end
  end

  assign pwm_hi_o = pwm_hi_q;
  assign pwm_lo_o = pwm_lo_q;
  assign oe_hi_o  = oe_q;
  assign oe_lo_o  = oe_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Randomized bench for pwm_deadtime against a gap/side behavioural model.
// Latency: model tracks 1 cycle, or 3 with PWMDT_SYNC_EN.
// Backpressure: none; register bus is strobe-based.
module tb_pwm_deadtime;

  localparam int DT_W   = 16;
  localparam int STAT_W = 4;
  localparam int ADDR_W = 8;
`ifdef PWMDT_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              re_i;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       wdata_i;
  logic [31:0]       rdata_o;
  logic              pwm_i;
  logic              pwm_hi_o, pwm_lo_o, oe_hi_o, oe_lo_o;

  always #5 clk_i = ~clk_i;

  pwm_deadtime #(.DT_W(DT_W), .STAT_W(STAT_W), .ADDR_W(ADDR_W)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .re_i     (re_i),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .rdata_o  (rdata_o),
    .pwm_i    (pwm_i),
    .pwm_hi_o (pwm_hi_o),
    .pwm_lo_o (pwm_lo_o),
    .oe_hi_o  (oe_hi_o),
    .oe_lo_o  (oe_lo_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Behavioural model: which side is driving, and an optional pending gap before a side takes over
  logic [3:0]        m_ctrl;
  logic [15:0]       m_dtr, m_dtf;
  logic [STAT_W-1:0] m_stat;
  int                m_side;      // 0 none, 1 low side on, 2 high side on
  bit                m_gap;       // a dead-time gap is in progress
  bit                m_gap_to_hi; // side that wins when the gap ends
  int                m_gap_left;
  bit                m_hist[$];   // pwm_i delayed by the synchronizer depth
  logic              e_hi, e_lo, e_oe, e_pol_hi, e_pol_lo;

  function automatic logic [31:0] read_model(input logic [7:0] a);
    case (a)
      8'h00:   return {28'd0, m_ctrl};
      8'h04:   return {16'd0, m_dtr};
      8'h08:   return {16'd0, m_dtf};
      8'h0C:   return 32'(m_stat);
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = '0; m_dtr = '0; m_dtf = '0; m_stat = '0;
    m_side = 0; m_gap = 0; m_gap_to_hi = 0; m_gap_left = 0;
    m_hist.delete();
    for (int i = 0; i < SYNC_LAT; i++) m_hist.push_back(1'b0);
    e_hi = 0; e_lo = 0; e_oe = 0; e_pol_hi = 0; e_pol_lo = 0;
  endtask

  // One rising clock edge of the model, using the inputs that were held across it
  task automatic model_edge();
    bit s, swallowed;
    int dt;
    m_hist.push_back(pwm_i);
    s = m_hist.pop_front();
    swallowed = 0;
    if (!m_ctrl[0] || m_ctrl[3]) begin
      m_side = 0; m_gap = 0;
    end else if (m_gap) begin
      if (s != m_gap_to_hi) begin
        swallowed = 1; m_gap = 0; m_side = s ? 2 : 1;
      end else if (m_gap_left <= 1) begin
        m_gap = 0; m_side = m_gap_to_hi ? 2 : 1;
      end else begin
        m_gap_left--;
      end
    end else if (m_side == 0) begin
      if (!s) m_side = 1;
      else begin m_gap = 1; m_gap_to_hi = 1; m_gap_left = int'(m_dtr); end
    end else if (s != (m_side == 2)) begin
      dt = s ? int'(m_dtr) : int'(m_dtf);
      if (dt == 0) m_side = s ? 2 : 1;
      else begin m_side = 0; m_gap = 1; m_gap_to_hi = s; m_gap_left = dt; end
    end
    e_pol_hi = m_ctrl[1];
    e_pol_lo = m_ctrl[2];
    e_hi = (m_side == 2) ^ e_pol_hi;
    e_lo = (m_side == 1) ^ e_pol_lo;
    e_oe = m_ctrl[0];
    if (swallowed && m_stat != '1) m_stat = m_stat + 1'b1;
    if (we_i && !re_i) begin
      case (addr_i)
        8'h00: m_ctrl = wdata_i[3:0];
        8'h04: m_dtr  = wdata_i[15:0];
        8'h08: m_dtf  = wdata_i[15:0];
        8'h0C: m_stat = '0;
        default: ;
      endcase
    end
  endtask

  // One bus/PWM cycle: drive, check read data, clock, check outputs against the model
  task automatic cyc(input bit pwm, input bit wr, input bit rd, input logic [7:0] a, input logic [31:0] d);
    pwm_i = pwm; we_i = wr; re_i = rd; addr_i = a; wdata_i = d;
    #1;
    check_eq("rdata", rdata_o, read_model(a));
    @(posedge clk_i);
    model_edge();
    #1;
    check_eq("pwm_hi", pwm_hi_o, e_hi);
    check_eq("pwm_lo", pwm_lo_o, e_lo);
    check_eq("oe_hi", oe_hi_o, e_oe);
    check_eq("oe_lo", oe_lo_o, e_oe);
    check_eq("hi_lo_excl", (pwm_hi_o ^ e_pol_hi) & (pwm_lo_o ^ e_pol_lo), 0);
  endtask

  task automatic idle(input bit pwm);
    logic [7:0] a;
    a = 8'($urandom_range(0, 4) * 4);
    cyc(pwm, 0, 1, a, $urandom());
  endtask

  task automatic wr(input bit pwm, input logic [7:0] a, input logic [31:0] d);
    cyc(pwm, 1, 0, a, d);
  endtask

  task automatic read_now(input string tag, input logic [7:0] a, input logic [31:0] exp);
    we_i = 0; re_i = 1; addr_i = a;
    #1;
    check_eq(tag, rdata_o, exp);
  endtask

  // Asynchronous reset mid-cycle: outputs must drop at once and all registers read 0
  task automatic do_reset();
    logic [7:0] a;
    rst_ni = 1'b0;
    we_i = 0; re_i = 0;
    #1;
    check_eq("rst_hi", pwm_hi_o, 0);
    check_eq("rst_lo", pwm_lo_o, 0);
    check_eq("rst_oe_hi", oe_hi_o, 0);
    check_eq("rst_oe_lo", oe_lo_o, 0);
    for (int i = 0; i < 4; i++) begin
      a = 8'(i * 4);
      read_now("rst_reg", a, 0);
    end
    model_reset();
    @(posedge clk_i);
    @(posedge clk_i);
    #3;
    rst_ni = 1'b1;
  endtask

  initial begin
    bit saw_hi, lvl;
    int run, r;
    logic [31:0] rv, hi16;
    pwm_i = 0; we_i = 0; re_i = 0; addr_i = '0; wdata_i = '0;
    do_reset();

    // Dead time 4/4, rising edge after 20 low cycles
    wr(0, 8'h00, 32'h1);
    wr(0, 8'h04, 32'd4);
    wr(0, 8'h08, 32'd4);
    repeat (20) idle(0);
    for (int k = 1; k <= 15; k++) begin
      idle(1);
      check_eq("s1_lo", pwm_lo_o, 32'(k < SYNC_LAT + 1));
      check_eq("s1_hi", pwm_hi_o, 32'(k >= SYNC_LAT + 5));
    end

    // Short pulse swallowed, then saturation of the counter and clear
    repeat (10) idle(0);
    wr(0, 8'h0C, 32'h0);
    wr(0, 8'h04, 32'd5);
    repeat (10) idle(0);
    saw_hi = 0;
    idle(1); saw_hi |= pwm_hi_o;
    idle(1); saw_hi |= pwm_hi_o;
    repeat (10) begin idle(0); saw_hi |= pwm_hi_o; end
    check_eq("s2_no_hi", saw_hi, 0);
    read_now("s2_status_one", 8'h0C, 32'd1);
    wr(0, 8'h0C, 32'hDEAD_BEEF);
    read_now("s2_status_clr", 8'h0C, 32'd0);
    repeat (20) begin
      idle(1); idle(1);
      repeat (4) idle(0);
    end
    read_now("s2_status_sat", 8'h0C, 32'((1 << STAT_W) - 1));

    // Zero dead time, square wave period 20
    wr(0, 8'h04, 32'd0);
    wr(0, 8'h08, 32'd0);
    repeat (4) begin
      repeat (10) idle(1);
      repeat (10) idle(0);
    end

    // Inverted polarities with dead time 3
    wr(0, 8'h00, 32'h7);
    wr(0, 8'h04, 32'd3);
    wr(0, 8'h08, 32'd3);
    repeat (3) begin
      repeat (10) idle(1);
      repeat (10) idle(0);
    end

    // force_safe during HI_ON, then release with pwm high
    wr(0, 8'h00, 32'h1);
    repeat (10) idle(1);
    wr(1, 8'h00, 32'h9);
    repeat (5) idle(1);
    wr(1, 8'h00, 32'h1);
    repeat (10) idle(1);
    repeat (5) idle(0);

    // Reset in the middle of a long falling gap
    wr(0, 8'h08, 32'd8);
    repeat (10) idle(1);
    repeat (SYNC_LAT + 3) idle(0);
    do_reset();

    // Random traffic
    wr(0, 8'h00, 32'h1);
    lvl = 0; run = 0;
    for (int c = 0; c < 3000; c++) begin
      if (run == 0) begin
        lvl = ~lvl;
        run = $urandom_range(1, 12);
      end
      run--;
      r = $urandom_range(0, 199);
      rv = $urandom();
      hi16 = {rv[31:16], 16'd0};
      if (r < 5) begin
        rv[0] = ($urandom_range(0, 7) != 0);
        rv[3] = ($urandom_range(0, 7) == 0);
        wr(lvl, 8'h00, rv);
      end else if (r < 12) begin
        wr(lvl, (r < 8) ? 8'h04 : 8'h08, hi16 | 32'($urandom_range(0, 7)));
      end else if (r < 13) begin
        wr(lvl, 8'h0C, rv);
      end else if (r < 17) begin
        cyc(lvl, 1, 1, 8'($urandom_range(0, 4) * 4), rv);
      end else begin
        idle(lvl);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime.md
Name: pwm_deadtime

Overview:
- Downstream stage of the PWM timer. Consumes one PWM waveform (o_pwm) and produces a complementary high-side/low-side pair with programmable dead time on rising and falling edges.
- Sits on the same simple register bus (re_i/we_i/addr_i/wdata_i/rdata_o) as the PWM timer; its outputs drive pads via pinmux with output enables.
- Pulses shorter than the dead time are swallowed and counted.

Parameters:
- DT_W, 16, width of dead-time counters and DT registers
- STAT_W, 16, width of saturating swallowed-pulse counter
- ADDR_W, 8, register address width

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  reset, asynchronous, active-low
- re_i  input  1  register read strobe
- we_i  input  1  register write strobe; a write occurs when we_i & ~re_i
- addr_i  input  ADDR_W  byte address
- wdata_i  input  32  write data
- rdata_o  output  32  read data, combinational from addr_i
- pwm_i  input  1  raw PWM from timer (derived-clock domain)
- pwm_hi_o  output  1  high-side drive
- pwm_lo_o  output  1  low-side drive
- oe_hi_o  output  1  high-side output enable
- oe_lo_o  output  1  low-side output enable

Behaviour:
- Registers (all async reset to 0):
  - 0x00 CTRL[3:0]: [0] en, [1] pol_hi, [2] pol_lo, [3] force_safe.
  - 0x04 DT_RISE[DT_W-1:0]: low-off to high-on gap, in clk_i cycles.
  - 0x08 DT_FALL[DT_W-1:0]: high-off to low-on gap, in clk_i cycles.
  - 0x0C STATUS[STAT_W-1:0]: read-only swallowed-pulse count; any write to 0x0C clears it.
- Register access rules:
  - Unmapped reads return 0; unmapped writes are ignored.
  - Read data is zero-extended to 32 bits.
- Input path: pwm_i passes through a 2-flop synchronizer to give pwm_s.
- FSM states: OFF, LO_ON, DT_RISE, HI_ON, DT_FALL. A down-counter cnt is used in the DT states.
- OFF:
  - Entered on reset, when en=0, or when force_safe=1. Both exits are evaluated every cycle, from any state, with priority over all other transitions; cnt is cleared.
  - When en=1 and force_safe=0: go to LO_ON if pwm_s=0, otherwise to DT_RISE with cnt=DT_RISE.
- LO_ON: on pwm_s=1, go to DT_RISE with cnt=DT_RISE. If DT_RISE=0, go directly to HI_ON.
- DT_RISE:
  - pwm_s=0: go to LO_ON and increment STATUS (saturating at all-ones).
  - Else if cnt==1 (or DT_RISE was 0): go to HI_ON.
  - Else: cnt-1.
- HI_ON: on pwm_s=0, go to DT_FALL with cnt=DT_FALL. If DT_FALL=0, go directly to LO_ON.
- DT_FALL: mirror of DT_RISE. pwm_s=1 returns to HI_ON and increments STATUS.
- Dead-time length: DT value N≥1 keeps both active levels off for exactly N cycles.
- Outputs (registered, derived from the next state):
  - Active levels: hi_act = (state==HI_ON), lo_act = (state==LO_ON).
  - pwm_hi_o = hi_act ^ pol_hi; pwm_lo_o = lo_act ^ pol_lo.
  - Outputs sit at their inactive level (the pol bit) in OFF and DT states.
  - oe_hi_o = oe_lo_o = en, registered.
- Reset values: pwm_hi_o, pwm_lo_o, oe_hi_o, oe_lo_o and rdata_o are all 0.
- Latency: with DT=0, a pwm_i edge reaches the outputs 3 clk_i cycles later (2 sync + 1 state).
- DT register writes during a DT state do not reload cnt; the new value applies at the next edge.
- Invariant: hi_act & lo_act is never 1. The bench asserts this.

Optional Feature:
- PWMDT_SYNC_EN defined: the 2-flop synchronizer is present, as described above.
- PWMDT_SYNC_EN undefined: pwm_s = pwm_i directly, for a pwm_i already in the clk_i domain. All latencies drop by 2 cycles.

Decomposition:
- pwm_dt_pkg:
  - state enum dt_state_e {OFF, LO_ON, DT_RISE, HI_ON, DT_FALL}
  - address constants ADR_CTRL/ADR_DT_RISE/ADR_DT_FALL/ADR_STATUS
  - CTRL bit index constants
- Sub-module pwm_dt_sync: 2-flop synchronizer, async active-low reset to 0.

Test Plan:
- Reset, then CTRL=0x1, DT_RISE=4, DT_FALL=4, pwm_i 0 for 20 cycles and then high -> lo=1 until 3 cycles after the edge; both low for 4 cycles; then hi=1.
- pwm_i high pulse of 2 cycles with DT_RISE=5 -> hi never asserts, lo gap of 2 cycles, STATUS reads 1; a write to 0x0C makes STATUS read 0.
- DT_RISE=0, DT_FALL=0, 50% square wave with period 20 -> hi/lo exact complements with no gap, 3-cycle lag.
- CTRL=0x7 (both pols inverted) -> outputs are inverted; dead-time phases read hi=1, lo=1.
- force_safe set mid-HI_ON -> both outputs inactive next cycle; clearing it resumes via LO_ON/DT_RISE per pwm_s.
- Async rst_ni pulse mid-DT_FALL -> outputs and oe become 0 immediately; all registers read 0.
